// File: rtl/parallel_interface_pkg.sv
// Shared widths, reset values and write-sequencer states for the parallel host bus slave.
package parallel_interface_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int REG_NUM_DEF = 8;
    localparam logic [DATA_W-1:0] REG_RST_VAL = 16'h0000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ARM  = 2'd1,
        W_HOLD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/parallel_interface_bus_sync.sv
// Strobe synchronizers plus an addr/data sample pipeline of equal depth so that
// the sampled bus fields line up with the synchronized strobes. STAGES must be >= 2.
module parallel_interface_bus_sync
    import parallel_interface_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              cs_s,
    output logic              rd_s,
    output logic              wr_s,
    output logic [ADDR_W-1:0] addr_s,
    output logic [DATA_W-1:0] data_s
);

    logic [STAGES-1:0] cs_q;
    logic [STAGES-1:0] rd_q;
    logic [STAGES-1:0] wr_q;
    logic [ADDR_W-1:0] addr_q [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= '1;
            rd_q <= '1;
            wr_q <= '1;
            for (int i = 0; i < STAGES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            cs_q <= {cs_q[STAGES-2:0], cs_n};
            rd_q <= {rd_q[STAGES-2:0], rd_n};
            wr_q <= {wr_q[STAGES-2:0], wr_n};
            addr_q[0] <= addr;
            data_q[0] <= data_in;
            for (int i = 1; i < STAGES; i++) begin
                addr_q[i] <= addr_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign cs_s   = cs_q[STAGES-1];
    assign rd_s   = rd_q[STAGES-1];
    assign wr_s   = wr_q[STAGES-1];
    assign addr_s = addr_q[STAGES-1];
    assign data_s = data_q[STAGES-1];

endmodule

// File: rtl/parallel_interface.sv
// Parallel host bus slave: synchronized strobes drive a write sequencer and a
// registered read path over a small 16-bit register file.
//
//   state  | meaning
//   W_IDLE | waiting for the first cs+wr low sample
//   W_ARM  | one low sample seen; a second one commits the write
//   W_HOLD | write committed; wait for synchronized wr_n high
module parallel_interface
    import parallel_interface_pkg::*;
#(
    parameter int REG_NUM     = REG_NUM_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    inout  wire  [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr
);

    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(REG_NUM);

    logic              cs_s, rd_s, wr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;

    wr_state_t         state, state_nxt;
    logic              commit;
    logic              wr_act, rd_act, addr_ok;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [DATA_W-1:0] dout;
    logic              oe;

    parallel_interface_bus_sync #(
        .STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .addr    (addr),
        .data_in (data),
        .cs_s    (cs_s),
        .rd_s    (rd_s),
        .wr_s    (wr_s),
        .addr_s  (addr_s),
        .data_s  (data_s)
    );

    assign wr_act  = !cs_s && !wr_s;
    assign rd_act  = !cs_s && !rd_s && wr_s;
    assign addr_ok = addr_s < REG_LIMIT;
    assign idx     = addr_s[IDX_W-1:0];

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= W_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            W_IDLE: if (wr_act) state_nxt = W_ARM;
            W_ARM: begin
                if (wr_act) begin
                    commit    = 1'b1;
                    state_nxt = W_HOLD;
                end else begin
                    state_nxt = W_IDLE;
                end
            end
            // Only a returning wr_n ends the pulse; cs_n bouncing must not re-arm.
            W_HOLD: if (wr_s) state_nxt = W_IDLE;
            default: state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= REG_RST_VAL;
        end else if (commit && addr_ok) begin
            regs[idx] <= data_s;
        end
    end

    // Same-edge commit and read: the non-blocking read sees the old register value.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            oe   <= 1'b0;
            dout <= REG_RST_VAL;
        end else if (rd_act) begin
            oe   <= 1'b1;
            dout <= addr_ok ? regs[idx] : REG_RST_VAL;
        end else begin
            oe   <= 1'b0;
        end
    end

    // oe lags wr_s by one edge; the wr_s gate keeps the bus quiet during a write.
    assign data = (oe && wr_s) ? dout : {DATA_W{1'bz}};

endmodule

// File: tb/tb_parallel_interface.sv
// Bench for parallel_interface: table-driven host writes/reads with a read scoreboard,
// plus hand-written reset, chip-select, priority and address-tracking sequences.
module tb_parallel_interface;

    logic        tb_sclk;
    logic        rst_n;
    logic        cs_n, rd_n, wr_n;
    logic [7:0]  addr;
    logic        drv_en;
    logic [15:0] drv_val;
    // Pulled high so an undriven bus reads 0xFFFF; no test stores 0xFFFF in a register.
    tri1  [15:0] data_bus;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb_q [$];

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [15:0] d;
    } vec_t;

    vec_t vec_fill [$];
    vec_t vec_after [$];

    assign data_bus = drv_en ? drv_val : 16'hzzzz;

    parallel_interface dut (
        .sclk  (tb_sclk),
        .rst_n (rst_n),
        .cs_n  (cs_n),
        .rd_n  (rd_n),
        .wr_n  (wr_n),
        .data  (data_bus),
        .addr  (addr)
    );

    initial tb_sclk = 1'b0;
    always #5 tb_sclk = ~tb_sclk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge tb_sclk);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_z(input string name);
        check16(name, data_bus, 16'hFFFF);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        addr = a;
        cyc(2);
        wr_n = 1'b0;
        drv_val = d;
        drv_en = 1'b1;
        cyc(4);
        wr_n = 1'b1;
        drv_en = 1'b0;
        cyc(2);
    endtask

    task automatic host_read(input string name, input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] e;
        addr = a;
        rd_n = 1'b0;
        sb_q.push_back(exp);
        cyc(4);
        e = sb_q.pop_front();
        check16(name, data_bus, e);
        rd_n = 1'b1;
        cyc(3);
        check_z({name, "_release"});
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wr) host_write(v.a, v.d);
        else      host_read($sformatf("rd_a%0h", v.a), v.a, v.d);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) vec_fill.push_back('{1'b1, 8'(i), 16'(i)});
        for (int i = 0; i < 8; i++) vec_fill.push_back('{1'b0, 8'(i), 16'(i)});
        vec_after.push_back('{1'b1, 8'h20, 16'hFFFF});
        vec_after.push_back('{1'b0, 8'h20, 16'h0000});
        for (int i = 0; i < 8; i++)
            vec_after.push_back('{1'b0, 8'(i), (i == 3) ? 16'hA5A5 : 16'h0000});

        rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 8'h00; drv_en = 1'b0; drv_val = 16'h0000;
        cyc(3);
        check_z("reset_bus_z");
        rst_n = 1'b1;
        cyc(2);
        check_z("idle_bus_z");

        cs_n = 1'b0;
        cyc(1);
        foreach (vec_fill[i]) run_vec(vec_fill[i]);

        // Reset lands mid-write to addr 1: nothing may commit and the bus releases at once.
        addr = 8'h01;
        cyc(2);
        wr_n = 1'b0; drv_val = 16'h5555; drv_en = 1'b1;
        cyc(2);
        drv_en = 1'b0;
        rst_n = 1'b0;
        #1 check_z("rst_mid_write_z");
        cyc(2);
        wr_n = 1'b1;
        check_z("rst_held_z");
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        check_z("after_rst_z");
        host_read("rst_no_commit_a1", 8'h01, 16'h0000);
        host_read("rst_cleared_a2", 8'h02, 16'h0000);

        host_write(8'h03, 16'hA5A5);
        host_read("a5_a3", 8'h03, 16'hA5A5);
        host_read("a5_a4", 8'h04, 16'h0000);

        cs_n = 1'b1;
        cyc(1);
        check_z("cs_high_pre_z");
        host_write(8'h02, 16'h1234);
        check_z("cs_high_write_z");
        cs_n = 1'b0;
        cyc(1);
        host_read("cs_high_a2", 8'h02, 16'h0000);

        foreach (vec_after[i]) run_vec(vec_after[i]);

        // rd_n and wr_n low together: the write wins and the DUT stays off the bus.
        addr = 8'h05;
        cyc(2);
        rd_n = 1'b0; wr_n = 1'b0; drv_val = 16'h0BEE; drv_en = 1'b1;
        cyc(4);
        check16("rw_both_bus", data_bus, 16'h0BEE);
        rd_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
        cyc(3);
        check_z("rw_both_release_z");
        host_read("rw_both_a5", 8'h05, 16'h0BEE);

        // Read data follows an address change while rd_n stays low.
        addr = 8'h03;
        rd_n = 1'b0;
        sb_q.push_back(16'hA5A5);
        cyc(4);
        check16("track_a3", data_bus, sb_q.pop_front());
        addr = 8'h05;
        sb_q.push_back(16'h0BEE);
        cyc(3);
        check16("track_a5", data_bus, sb_q.pop_front());
        rd_n = 1'b1;
        cyc(3);
        check_z("track_release_z");

        cs_n = 1'b1;
        cyc(2);
        check_z("all_high_z");

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_empty: got %0d entries expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
